// File: rtl/ro_puf_ctrl_if.sv
// ro_puf_ctrl_if -- request/response bundle for the RO-PUF controller.
//
// Handshake: the master presents idx_a/idx_b/win_len with start=1 for one
// or more cycles; the controller accepts on the first clk edge where it is
// idle (busy=0) and start=1. From the following cycle busy=1 and further
// start pulses are ignored. The result (resp/tie/err) is valid when done
// pulses for one cycle and stays stable until the next accept.
//
// Signals:
//   start    master->slave  request strobe
//   idx_a    master->slave  first RO index
//   idx_b    master->slave  second RO index
//   win_len  master->slave  counting window length in clk cycles
//   busy     slave->master  measurement in progress
//   done     slave->master  one-cycle result strobe
//   resp     slave->master  1 iff count of RO a > count of RO b
//   tie      slave->master  counts equal
//   err      slave->master  illegal request
interface ro_puf_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int WIN_W = 16
);
  logic             start;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic             done;
  logic             resp;
  logic             tie;
  logic             err;

  modport master (
    output start, idx_a, idx_b, win_len,
    input  busy, done, resp, tie, err
  );

  modport slave (
    input  start, idx_a, idx_b, win_len,
    output busy, done, resp, tie, err
  );
endinterface

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl -- ring-oscillator PUF pair-comparison controller.
//
// Enables two ROs of an external bank, lets them settle, counts rising
// edges of each over a programmable window, then reports which ran faster.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   bus        ro_puf_ctrl_if.slave request/response bundle
//   ro_in      raw RO outputs (asynchronous to clk)
//   ro_en      per-RO enable, exactly two bits set while measuring
//   dbg_state  current FSM state encoding
//   cnt_a_o    final count of RO a  (only with ROPUF_CNT_OBS_EN)
//   cnt_b_o    final count of RO b  (only with ROPUF_CNT_OBS_EN)
//
// Optional feature: define ROPUF_CNT_OBS_EN to expose the final counts.
// Without it the raw counts never leave the block.
module ro_puf_ctrl #(
  parameter int NUM_RO = 16,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4,
  parameter int IDX_W  = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst,
  ro_puf_ctrl_if.slave      bus,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
`ifdef ROPUF_CNT_OBS_EN
  output logic [CNT_W-1:0]  cnt_a_o,
  output logic [CNT_W-1:0]  cnt_b_o,
`endif
  output logic [2:0]        dbg_state
);

  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_COUNT  = 3'd2,
    S_CMP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_a_q;
  logic [IDX_W-1:0] idx_b_q;
  logic [WIN_W-1:0] win_cnt;
  logic [SET_W-1:0] set_cnt;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             illegal_q;

  // sync_x[0..1] form the synchroniser, sync_x[2] is the edge-detect history.
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic             sel_a;
  logic             sel_b;
  logic             edge_a;
  logic             edge_b;
  logic             req_illegal;
  logic             idx_a_ok;
  logic             idx_b_ok;

  assign dbg_state = state;

  // Index range check widened by one bit so NUM_RO itself is representable.
  assign idx_a_ok = ({1'b0, bus.idx_a} < (IDX_W + 1)'(NUM_RO));
  assign idx_b_ok = ({1'b0, bus.idx_b} < (IDX_W + 1)'(NUM_RO));

  assign req_illegal = (bus.idx_a == bus.idx_b) || !idx_a_ok || !idx_b_ok ||
                       (bus.win_len == '0);

  // Selected RO lines. The mux sits ahead of the synchroniser; any glitch
  // from the mux is absorbed there. An illegal request never counts, so an
  // out-of-range latched index is harmless.
  assign sel_a  = ro_in[idx_a_q];
  assign sel_b  = ro_in[idx_b_q];

  assign edge_a = sync_a[1] & ~sync_a[2];
  assign edge_b = sync_b[1] & ~sync_b[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      win_cnt   <= '0;
      set_cnt   <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      illegal_q <= 1'b0;
      sync_a    <= '0;
      sync_b    <= '0;
      ro_en     <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.resp  <= 1'b0;
      bus.tie   <= 1'b0;
      bus.err   <= 1'b0;
`ifdef ROPUF_CNT_OBS_EN
      cnt_a_o   <= '0;
      cnt_b_o   <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      sync_a   <= {sync_a[1:0], sel_a};
      sync_b   <= {sync_b[1:0], sel_b};

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx_a_q   <= bus.idx_a;
            idx_b_q   <= bus.idx_b;
            win_cnt   <= bus.win_len;
            set_cnt   <= SET_W'(SETTLE);
            cnt_a     <= '0;
            cnt_b     <= '0;
            illegal_q <= req_illegal;
            bus.busy  <= 1'b1;
            bus.resp  <= 1'b0;
            bus.tie   <= 1'b0;
            bus.err   <= 1'b0;
`ifdef ROPUF_CNT_OBS_EN
            cnt_a_o   <= '0;
            cnt_b_o   <= '0;
`endif
            if (req_illegal) begin
              // Illegal requests skip the measurement but still pass
              // through the compare slot, giving a fixed 2-cycle latency.
              state <= S_CMP;
            end else begin
              state <= S_SETTLE;
              ro_en <= (NUM_RO'(1) << bus.idx_a) | (NUM_RO'(1) << bus.idx_b);
            end
          end
        end

        S_SETTLE: begin
          // Counters stay at 0; the settle time also fills the synchroniser
          // so the first counting cycle never sees a stale edge.
          set_cnt <= set_cnt - SET_W'(1);
          if (set_cnt == SET_W'(1)) begin
            state <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (edge_a && (cnt_a != {CNT_W{1'b1}})) begin
            cnt_a <= cnt_a + CNT_W'(1);
          end
          if (edge_b && (cnt_b != {CNT_W{1'b1}})) begin
            cnt_b <= cnt_b + CNT_W'(1);
          end
          win_cnt <= win_cnt - WIN_W'(1);
          if (win_cnt == WIN_W'(1)) begin
            state <= S_CMP;
            ro_en <= '0;
          end
        end

        S_CMP: begin
          bus.resp <= !illegal_q && (cnt_a > cnt_b);
          bus.tie  <= !illegal_q && (cnt_a == cnt_b);
          bus.err  <= illegal_q;
`ifdef ROPUF_CNT_OBS_EN
          cnt_a_o  <= cnt_a;
          cnt_b_o  <= cnt_b;
`endif
          bus.done <= 1'b1;
          state    <= S_DONE;
        end

        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          ro_en    <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
